cu_fetch_sequencer: RTL

- Multi-cycle instruction-fetch sequencer for the control unit.
- Issues a memory read for the current PC and holds the request across a variable-latency handshake.
- Latches the fetched word into IR and hands it to the decode stage over a valid/ack handshake.
- Advances PC sequentially, or to a branch/flush target, and raises a sticky fault on memory timeout.

---
 rtl/cu_fetch_sequencer_if.sv | 25 ++
 rtl/cu_fetch_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cu_fetch_sequencer_if.sv
// Memory-read and decode-handoff signals of the instruction-fetch sequencer.
// master = sequencer side, slave = memory / decode side.
interface cu_fetch_sequencer_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 64
);
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] ir;
  logic               ir_load;
  logic               instr_valid;
  logic               instr_ack;

  modport master (
    output mem_req, mem_addr, ir, ir_load, instr_valid,
    input  mem_ready, mem_rdata, instr_ack
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_load, instr_valid,
    output mem_ready, mem_rdata, instr_ack
  );
endinterface

// File: rtl/cu_fetch_sequencer.sv
// Multi-cycle instruction fetch: request/wait on memory, latch IR, hand off to
// decode, advance PC sequentially or to a branch/flush target, fault on timeout.
module cu_fetch_sequencer #(
  parameter int              INSTR_W  = 32,
  parameter int              PC_W     = 64,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  cu_fetch_sequencer_if.master bus,
  input  logic                run,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_target,
  input  logic                flush,
  input  logic [PC_W-1:0]     flush_target,
  output logic [PC_W-1:0]     pc,
  output logic                fault,
  output logic [2:0]          state
);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_HANDOFF = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t             st;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_next;
  logic [PC_W-1:0]    addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic [CNT_W-1:0]   cnt;
  logic               discard;
  logic               req_q;
  logic               valid_q;
  logic               fault_q;
  logic               in_flight;
  logic               capture;

  assign in_flight = (st == S_REQ) || (st == S_WAIT);
  // A response is only kept when no flush is pending or arriving alongside it.
  assign capture   = req_q && bus.mem_ready && !discard && !flush;

  always_comb begin
    pc_next = pc_q;
    if (flush)
      pc_next = flush_target;
    else if (st == S_HANDOFF && bus.instr_ack)
      pc_next = branch_taken ? branch_target : pc_q + PC_W'(PC_STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      cnt     <= '0;
      discard <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (capture)
        ir_q <= bus.mem_rdata;
      if (flush) begin
        cnt     <= '0;
        fault_q <= 1'b0;
        valid_q <= 1'b0;
        if (in_flight && !bus.mem_ready) begin
          // Old access must still finish on the bus; its data is thrown away.
          st      <= S_WAIT;
          discard <= 1'b1;
          req_q   <= 1'b1;
        end else if (in_flight || run) begin
          st      <= S_REQ;
          discard <= 1'b0;
          req_q   <= 1'b1;
          addr_q  <= pc_next;
        end else begin
          st      <= S_IDLE;
          discard <= 1'b0;
          req_q   <= 1'b0;
        end
      end else begin
        case (st)
          S_IDLE: begin
            if (run && !stall) begin
              st     <= S_REQ;
              req_q  <= 1'b1;
              addr_q <= pc_next;
            end
          end
          S_REQ, S_WAIT: begin
            if (bus.mem_ready) begin
              cnt <= '0;
              if (discard) begin
                st      <= S_REQ;
                discard <= 1'b0;
                addr_q  <= pc_next;
              end else begin
                st      <= S_HANDOFF;
                req_q   <= 1'b0;
                valid_q <= 1'b1;
              end
            end else if (st == S_REQ) begin
              st  <= S_WAIT;
              cnt <= CNT_W'(1);
            end else if (TIMEOUT != 0 && !discard && cnt == TIMEOUT_C) begin
              st      <= S_FAULT;
              req_q   <= 1'b0;
              fault_q <= 1'b1;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_HANDOFF: begin
            if (bus.instr_ack) begin
              valid_q <= 1'b0;
              if (run && !stall) begin
                st     <= S_REQ;
                req_q  <= 1'b1;
                addr_q <= pc_next;
              end else begin
                st <= S_IDLE;
              end
            end
          end
          S_FAULT: st <= S_FAULT;
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.ir          = ir_q;
  assign bus.ir_load     = capture;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign fault           = fault_q;
  assign state           = st;
endmodule
